// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the 5-stage RV32I core.
// It captures the decoded operands and control fields, forwards MEM/WB
// results into the registered operands, and selects the EX-stage ALU inputs.
// It also flags load-use hazards back to decode.
// Optional feature macro: ID_EX_PERF_CNT_EN enables the stall and bubble
// performance counters. When it is undefined, both counter ports read 0.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [8:0]      id_ctrl,
  input  logic            mem_fwd_we,
  input  logic [4:0]      mem_fwd_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_fwd_we,
  input  logic [4:0]      wb_fwd_rd,
  input  logic [XLEN-1:0] wb_fwd_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_ctrl,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [XLEN-1:0] ex_store_data,
  output logic            load_use_hazard,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_bubble_cnt
);

  // Control word layout: {reg_write, mem_read, mem_write, alu_src_imm, alu_src_pc, alu_control[3:0]}
  localparam int CTRL_REG_WRITE = 8;
  localparam int CTRL_MEM_READ  = 7;
  localparam int CTRL_SRC_IMM   = 5;
  localparam int CTRL_SRC_PC    = 4;

  logic            valid_q,    valid_d;
  logic [XLEN-1:0] pc_q,       pc_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q,      imm_d;
  logic [4:0]      rs1_q,      rs1_d;
  logic [4:0]      rs2_q,      rs2_d;
  logic [4:0]      rd_q,       rd_d;
  logic [8:0]      ctrl_q,     ctrl_d;

  logic            mem_hit_rs1, wb_hit_rs1;
  logic            mem_hit_rs2, wb_hit_rs2;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  // Forwarding: the MEM-stage producer is younger, so it wins over WB; x0 is never forwarded
  always_comb begin
    mem_hit_rs1 = mem_fwd_we && (mem_fwd_rd != 5'd0) && (mem_fwd_rd == rs1_q);
    wb_hit_rs1  = wb_fwd_we  && (wb_fwd_rd  != 5'd0) && (wb_fwd_rd  == rs1_q);
    mem_hit_rs2 = mem_fwd_we && (mem_fwd_rd != 5'd0) && (mem_fwd_rd == rs2_q);
    wb_hit_rs2  = wb_fwd_we  && (wb_fwd_rd  != 5'd0) && (wb_fwd_rd  == rs2_q);

    if (mem_hit_rs1)     fwd_rs1 = mem_fwd_data;
    else if (wb_hit_rs1) fwd_rs1 = wb_fwd_data;
    else                 fwd_rs1 = rs1_data_q;

    if (mem_hit_rs2)     fwd_rs2 = mem_fwd_data;
    else if (wb_hit_rs2) fwd_rs2 = wb_fwd_data;
    else                 fwd_rs2 = rs2_data_q;
  end

  // Next-state selection: flush beats stall, and stall beats a fresh load
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    ctrl_d     = ctrl_q;

    if (flush) begin
      valid_d    = 1'b0;
      pc_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
      ctrl_d     = '0;
    end else if (stall) begin
      // Refresh operands so a value retiring out of WB during the stall is kept
      rs1_data_d = fwd_rs1;
      rs2_data_d = fwd_rs2;
    end else begin
      valid_d    = id_valid;
      pc_d       = id_pc;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      ctrl_d     = id_ctrl;
      if (!id_valid) begin
        // An empty decode slot becomes a bubble with no side effects
        ctrl_d = '0;
        rd_d   = '0;
      end
    end
  end

  // Stage register: synchronous reset clears every field
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      ctrl_q     <= ctrl_d;
    end
  end

  // Operand selection and registered outputs towards EX
  always_comb begin
    ex_valid      = valid_q;
    ex_pc         = pc_q;
    ex_rd         = rd_q;
    ex_ctrl       = ctrl_q[CTRL_REG_WRITE:CTRL_REG_WRITE-2];
    alu_control   = ctrl_q[3:0];
    alu_in1       = ctrl_q[CTRL_SRC_PC]  ? pc_q  : fwd_rs1;
    alu_in2       = ctrl_q[CTRL_SRC_IMM] ? imm_q : fwd_rs2;
    ex_store_data = fwd_rs2;
  end

  // Load-use detection: rs2 is compared even when the consumer does not use it
  always_comb begin
    load_use_hazard = valid_q && ctrl_q[CTRL_MEM_READ] && (rd_q != 5'd0) && id_valid &&
                      ((id_rs1 == rd_q) || (id_rs2 == rd_q));
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] bubble_cnt_q;

  // Performance counters: stall cycles, and bubbles from flush or an empty decode slot
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (stall && !flush) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush || (!stall && !id_valid)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`else
  assign perf_stall_cnt  = 32'd0;
  assign perf_bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a
// transaction-level model of the stage contents.
module tb_id_ex_stage;

  logic        clk;
  logic        rst, stall, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [8:0]  id_ctrl;
  logic        mem_fwd_we, wb_fwd_we;
  logic [4:0]  mem_fwd_rd, wb_fwd_rd;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        ex_valid, load_use_hazard;
  logic [31:0] ex_pc, alu_in1, alu_in2, ex_store_data;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_ctrl;
  logic [3:0]  alu_control;
  logic [31:0] perf_stall_cnt, perf_bubble_cnt;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_ctrl(id_ctrl),
    .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .alu_control(alu_control), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .ex_store_data(ex_store_data), .load_use_hazard(load_use_hazard),
    .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the instruction sitting in EX, as a record
  typedef struct {
    bit        valid;
    bit [31:0] pc, a, b, imm;
    bit [4:0]  rs1, rs2, rd;
    bit        reg_write, mem_read, mem_write, src_imm, src_pc;
    bit [3:0]  op;
  } ex_slot_t;

  ex_slot_t    m;
  bit [31:0]   m_stalls, m_bubbles;
  int          n_cmp, n_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Value a source register sees right now: newest producer first, x0 never bypassed
  function automatic bit [31:0] model_src(input bit [4:0] idx, input bit [31:0] stored);
    if (idx == 0) return stored;
    if (mem_fwd_we && mem_fwd_rd == idx) return mem_fwd_data;
    if (wb_fwd_we && wb_fwd_rd == idx) return wb_fwd_data;
    return stored;
  endfunction

  function automatic ex_slot_t empty_slot();
    ex_slot_t s;
    s = '{default: 0};
    return s;
  endfunction

  task automatic model_edge();
    bit [31:0] a_now, b_now;
    a_now = model_src(m.rs1, m.a);
    b_now = model_src(m.rs2, m.b);
    if (rst) begin
      m = empty_slot();
      m_stalls = 0;
      m_bubbles = 0;
    end else if (flush) begin
      m = empty_slot();
      m_bubbles++;
    end else if (stall) begin
      m.a = a_now;
      m.b = b_now;
      m_stalls++;
    end else begin
      m.pc = id_pc; m.a = id_rs1_data; m.b = id_rs2_data; m.imm = id_imm;
      m.rs1 = id_rs1; m.rs2 = id_rs2;
      m.valid     = id_valid;
      m.rd        = id_valid ? id_rd : 5'd0;
      m.reg_write = id_valid && id_ctrl[8];
      m.mem_read  = id_valid && id_ctrl[7];
      m.mem_write = id_valid && id_ctrl[6];
      m.src_imm   = id_valid && id_ctrl[5];
      m.src_pc    = id_valid && id_ctrl[4];
      m.op        = id_valid ? id_ctrl[3:0] : 4'd0;
      if (!id_valid) m_bubbles++;
    end
  endtask

  task automatic check_all(input string ctx);
    bit [31:0] a_now, b_now;
    bit        hz;
    a_now = model_src(m.rs1, m.a);
    b_now = model_src(m.rs2, m.b);
    hz = m.valid && m.mem_read && m.rd != 0 && id_valid && (id_rs1 == m.rd || id_rs2 == m.rd);
    check_eq({ctx, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, m.valid});
    check_eq({ctx, ".ex_pc"}, ex_pc, m.pc);
    check_eq({ctx, ".ex_rd"}, {27'd0, ex_rd}, {27'd0, m.rd});
    check_eq({ctx, ".ex_ctrl"}, {29'd0, ex_ctrl}, {29'd0, m.reg_write, m.mem_read, m.mem_write});
    check_eq({ctx, ".alu_control"}, {28'd0, alu_control}, {28'd0, m.op});
    check_eq({ctx, ".alu_in1"}, alu_in1, m.src_pc ? m.pc : a_now);
    check_eq({ctx, ".alu_in2"}, alu_in2, m.src_imm ? m.imm : b_now);
    check_eq({ctx, ".store_data"}, ex_store_data, b_now);
    check_eq({ctx, ".hazard"}, {31'd0, load_use_hazard}, {31'd0, hz});
`ifdef ID_EX_PERF_CNT_EN
    check_eq({ctx, ".perf_stall"}, perf_stall_cnt, m_stalls);
    check_eq({ctx, ".perf_bubble"}, perf_bubble_cnt, m_bubbles);
`else
    check_eq({ctx, ".perf_stall"}, perf_stall_cnt, 32'd0);
    check_eq({ctx, ".perf_bubble"}, perf_bubble_cnt, 32'd0);
`endif
  endtask

  // One clock: inputs are stable across the edge, model follows, then settle off-edge
  task automatic step();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic clear_inputs();
    rst = 0; stall = 0; flush = 0; id_valid = 0;
    id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_ctrl = 0;
    mem_fwd_we = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_fwd_we = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
  endtask

  task automatic drive_instr(input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd,
                             input bit [31:0] a, input bit [31:0] b, input bit [8:0] ctrl);
    id_valid = 1; id_pc = 32'h0000_1000; id_imm = 32'h0000_0040;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = a; id_rs2_data = b; id_ctrl = ctrl;
  endtask

  bit [31:0] stalls_before, bubbles_before;

  initial begin
    n_cmp = 0; n_err = 0;
    m = empty_slot(); m_stalls = 0; m_bubbles = 0;
    clear_inputs();
    #1;

    // Reset, then an idle cycle with an empty decode slot
    rst = 1; step(); step();
    rst = 0;
    check_eq("reset.ex_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("reset.ex_ctrl", {29'd0, ex_ctrl}, 32'd0);
    check_eq("reset.alu_in1", alu_in1, 32'd0);
    check_eq("reset.alu_in2", alu_in2, 32'd0);
    check_eq("reset.hazard", {31'd0, load_use_hazard}, 32'd0);
    step();
    check_all("idle");

    // ADD x4, x1, x2 with register operands 5 and 7
    drive_instr(5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 9'b1_0_0_0_0_0010);
    step();
    id_valid = 0;
    #1;
    check_eq("add.alu_in1", alu_in1, 32'd5);
    check_eq("add.alu_in2", alu_in2, 32'd7);
    check_eq("add.ex_valid", {31'd0, ex_valid}, 32'd1);
    check_eq("add.alu_control", {28'd0, alu_control}, 32'd2);

    // Forwarding precedence on rs1 = x3
    drive_instr(5'd3, 5'd0, 5'd8, 32'h11, 32'h22, 9'b1_0_0_0_0_0000);
    step();
    id_valid = 0;
    mem_fwd_we = 1; mem_fwd_rd = 3; mem_fwd_data = 32'hAA;
    wb_fwd_we = 1;  wb_fwd_rd = 3;  wb_fwd_data = 32'hBB;
    #1 check_eq("fwd.mem_beats_wb", alu_in1, 32'hAA);
    mem_fwd_we = 0;
    #1 check_eq("fwd.wb_only", alu_in1, 32'hBB);
    mem_fwd_we = 1; mem_fwd_rd = 0; wb_fwd_rd = 0;
    #1 check_eq("fwd.rd0_ignored", alu_in1, 32'h11);
    check_all("fwd");
    mem_fwd_we = 0; wb_fwd_we = 0;

    // Load-use: LW x5 in EX, consumer reads x5 through rs2
    drive_instr(5'd1, 5'd2, 5'd5, 32'h0, 32'h0, 9'b1_1_0_1_0_0000);
    step();
    id_rs1 = 1; id_rs2 = 5; id_valid = 1;
    #1 check_eq("lu.hazard", {31'd0, load_use_hazard}, 32'd1);
    check_all("lu");
    flush = 1;
    step();
    flush = 0; id_valid = 0;
    #1 check_eq("lu.flush_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("lu.flush_ctrl", {29'd0, ex_ctrl}, 32'd0);

    // Three-cycle stall, WB produces rs1 = x6 only during the first stalled cycle
    drive_instr(5'd6, 5'd7, 5'd9, 32'h10, 32'h20, 9'b1_0_0_0_0_0000);
    step();
    id_valid = 0;
    stall = 1; wb_fwd_we = 1; wb_fwd_rd = 6; wb_fwd_data = 32'h1234;
    step();
    wb_fwd_we = 0;
    step(); step();
    stall = 0;
    #1 check_eq("stall.kept_wb", alu_in1, 32'h1234);
    check_all("stall");

    // flush together with stall inserts a bubble
    drive_instr(5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 9'b1_0_0_0_0_0000);
    step();
    stalls_before = m_stalls; bubbles_before = m_bubbles;
    flush = 1; stall = 1;
    step();
    flush = 0; stall = 0; id_valid = 0;
    #1 check_eq("fs.ex_valid", {31'd0, ex_valid}, 32'd0);
`ifdef ID_EX_PERF_CNT_EN
    check_eq("fs.bubble_cnt", perf_bubble_cnt, bubbles_before + 32'd1);
    check_eq("fs.stall_cnt", perf_stall_cnt, stalls_before);
`endif
    check_all("fs");

    // Randomized traffic with small register indices to make hits frequent
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(0, 99) < 2);
      flush        = ($urandom_range(0, 99) < 10);
      stall        = ($urandom_range(0, 99) < 25);
      id_valid     = ($urandom_range(0, 99) < 75);
      id_pc        = $urandom;
      id_rs1_data  = $urandom;
      id_rs2_data  = $urandom;
      id_imm       = $urandom;
      id_rs1       = 5'($urandom_range(0, 7));
      id_rs2       = 5'($urandom_range(0, 7));
      id_rd        = 5'($urandom_range(0, 7));
      id_ctrl      = 9'($urandom);
      mem_fwd_we   = $urandom_range(0, 1) != 0;
      mem_fwd_rd   = 5'($urandom_range(0, 7));
      mem_fwd_data = $urandom;
      wb_fwd_we    = $urandom_range(0, 1) != 0;
      wb_fwd_rd    = 5'($urandom_range(0, 7));
      wb_fwd_data  = $urandom;
      #1 check_all("rand");
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
